// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 32-bit ALU between N_REQ requesters.
// Define ALU_ARB_FIXED_PRIO_EN for fixed lowest-index-first priority.
`timescale 1ns/1ps
module alu_arbiter #(
    parameter int N_REQ = 2,
    localparam int ID_W = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [N_REQ*32-1:0] req_a,
    input  logic [N_REQ*32-1:0] req_b,
    input  logic [N_REQ*4-1:0]  req_op,
    output logic [31:0]         alu_a,
    output logic [31:0]         alu_b,
    output logic [3:0]          alu_opcode,
    input  logic [31:0]         alu_result,
    input  logic                alu_zero,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [ID_W-1:0]     rsp_id,
    output logic [31:0]         rsp_result,
    output logic                rsp_zero
);

    localparam logic [3:0] NOP = 4'b1111;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;

    state_e          state_q;
    logic [31:0]     alu_a_q;
    logic [31:0]     alu_b_q;
    logic [3:0]      alu_op_q;
    logic [ID_W-1:0] cur_id_q;
    logic            rsp_valid_q;
    logic [ID_W-1:0] rsp_id_q;
    logic [31:0]     rsp_result_q;
    logic            rsp_zero_q;

    logic [ID_W-1:0] base;
    logic            gnt_vld;
    logic [ID_W-1:0] gnt_id;
    logic [ID_W:0]   sum;

    logic [31:0] a_arr  [N_REQ];
    logic [31:0] b_arr  [N_REQ];
    logic [3:0]  op_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign a_arr[i]  = req_a[32*i +: 32];
        assign b_arr[i]  = req_b[32*i +: 32];
        assign op_arr[i] = req_op[4*i +: 4];
    end

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign base = '0;
`else
    logic [ID_W-1:0] rr_ptr_q;
    logic [ID_W-1:0] rr_ptr_d;
    assign base = rr_ptr_q;
    assign rr_ptr_d = (cur_id_q == ID_W'(N_REQ - 1)) ? '0 : cur_id_q + ID_W'(1);
`endif

    // Scan downward so the lowest offset from base wins the grant.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        sum     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, base} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(N_REQ)) begin
                sum = sum - (ID_W+1)'(N_REQ);
            end
            if (req_valid[sum[ID_W-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_id  = sum[ID_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == S_IDLE && gnt_vld) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= NOP;
            cur_id_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            rr_ptr_q     <= '0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (gnt_vld) begin
                        alu_a_q  <= a_arr[gnt_id];
                        alu_b_q  <= b_arr[gnt_id];
                        alu_op_q <= op_arr[gnt_id];
                        cur_id_q <= gnt_id;
                        state_q  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    rsp_result_q <= alu_result;
                    rsp_zero_q   <= alu_zero;
                    rsp_id_q     <= cur_id_q;
                    rsp_valid_q  <= 1'b1;
                    alu_op_q     <= NOP;
                    state_q      <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        rr_ptr_q    <= rr_ptr_d;
`endif
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_op_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: N_REQ=2 and N_REQ=4 instances,
// each with a behavioural ALU on its operand outputs.
`timescale 1ns/1ps
module tb_alu_arbiter;

    typedef struct {
        int          id;
        logic [31:0] res;
        logic        z;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  req_valid, req_ready;
    logic [63:0] req_a, req_b;
    logic [7:0]  req_op;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_opcode;
    logic        alu_zero, rsp_valid, rsp_ready, rsp_zero;
    logic [0:0]  rsp_id;
    logic [31:0] rsp_result;

    logic [3:0]   w_req_valid, w_req_ready;
    logic [127:0] w_req_a, w_req_b;
    logic [15:0]  w_req_op;
    logic [31:0]  w_alu_a, w_alu_b, w_alu_result;
    logic [3:0]   w_alu_opcode;
    logic         w_alu_zero, w_rsp_valid, w_rsp_ready, w_rsp_zero;
    logic [1:0]   w_rsp_id;
    logic [31:0]  w_rsp_result;

    exp_t sb2[$];
    exp_t sb4[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << b[4:0];
            4'd6: return a >> b[4:0];
            4'd7: return $unsigned($signed(a) >>> b[4:0]);
            4'd8: return {31'd0, $signed(a) < $signed(b)};
            default: return 32'd0;
        endcase
    endfunction

    assign alu_result   = alu_ref(alu_a, alu_b, alu_opcode);
    assign alu_zero     = (alu_result == 32'd0);
    assign w_alu_result = alu_ref(w_alu_a, w_alu_b, w_alu_opcode);
    assign w_alu_zero   = (w_alu_result == 32'd0);

    alu_arbiter #(.N_REQ(2)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero)
    );

    alu_arbiter #(.N_REQ(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(w_req_valid), .req_ready(w_req_ready),
        .req_a(w_req_a), .req_b(w_req_b), .req_op(w_req_op),
        .alu_a(w_alu_a), .alu_b(w_alu_b), .alu_opcode(w_alu_opcode),
        .alu_result(w_alu_result), .alu_zero(w_alu_zero),
        .rsp_valid(w_rsp_valid), .rsp_ready(w_rsp_ready), .rsp_id(w_rsp_id),
        .rsp_result(w_rsp_result), .rsp_zero(w_rsp_zero)
    );

    always @(negedge clk) begin : mon2
        exp_t e;
        if (rst_n && rsp_valid && rsp_ready) begin
            checks++;
            if (sb2.size() == 0) begin
                errors++;
                $display("FAIL rsp2_unexpected: got id=%0d result=%h, required no response",
                         rsp_id, rsp_result);
            end else begin
                e = sb2.pop_front();
                if (int'(rsp_id) !== e.id || rsp_result !== e.res || rsp_zero !== e.z) begin
                    errors++;
                    $display("FAIL rsp2_data: got id=%0d res=%h z=%b, required id=%0d res=%h z=%b",
                             rsp_id, rsp_result, rsp_zero, e.id, e.res, e.z);
                end
            end
        end
    end

    always @(negedge clk) begin : mon4
        exp_t e;
        if (rst_n && w_rsp_valid && w_rsp_ready) begin
            checks++;
            if (sb4.size() == 0) begin
                errors++;
                $display("FAIL rsp4_unexpected: got id=%0d result=%h, required no response",
                         w_rsp_id, w_rsp_result);
            end else begin
                e = sb4.pop_front();
                if (int'(w_rsp_id) !== e.id || w_rsp_result !== e.res || w_rsp_zero !== e.z) begin
                    errors++;
                    $display("FAIL rsp4_data: got id=%0d res=%h z=%b, required id=%0d res=%h z=%b",
                             w_rsp_id, w_rsp_result, w_rsp_zero, e.id, e.res, e.z);
                end
            end
        end
    end

    task automatic drive2(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_op[4*i +: 4]  = op;
        req_valid[i]      = 1'b1;
    endtask

    task automatic drive4(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op);
        w_req_a[32*i +: 32] = a;
        w_req_b[32*i +: 32] = b;
        w_req_op[4*i +: 4]  = op;
        w_req_valid[i]      = 1'b1;
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 20 && (sb2.size() != 0 || sb4.size() != 0); c++) @(negedge clk);
        checks++;
        if (sb2.size() != 0 || sb4.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d/%0d pending, required 0/0", name,
                     sb2.size(), sb4.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b0;
        w_req_valid = '0; w_req_a = '0; w_req_b = '0; w_req_op = '0; w_rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (alu_opcode !== 4'hF) begin
            errors++;
            $display("FAIL reset_opcode: got %h, required f", alu_opcode);
        end
        checks++;
        if ({alu_a, alu_b} !== 64'd0) begin
            errors++;
            $display("FAIL reset_operands: got %h %h, required 0 0", alu_a, alu_b);
        end
        checks++;
        if ({rsp_valid, req_ready, rsp_id, rsp_zero, rsp_result} !== 37'd0) begin
            errors++;
            $display("FAIL reset_rsp: got v=%b rdy=%b id=%0d z=%b res=%h, required all 0",
                     rsp_valid, req_ready, rsp_id, rsp_zero, rsp_result);
        end
        checks++;
        if (w_rsp_valid !== 1'b0 || w_alu_opcode !== 4'hF || w_req_ready !== 4'd0) begin
            errors++;
            $display("FAIL reset_dut4: got v=%b op=%h rdy=%b, required 0 f 0",
                     w_rsp_valid, w_alu_opcode, w_req_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single_op();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        drive2(0, 32'd5, 32'd3, 4'd0);
        sb2.push_back('{0, 32'd8, 1'b0});
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL single_ready: got %b, required 01", req_ready);
        end
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        checks++;
        if ({rsp_valid, req_ready, alu_a, alu_b, alu_opcode} !== {1'b0, 2'b00, 32'd5, 32'd3, 4'd0}) begin
            errors++;
            $display("FAIL single_exec: got v=%b rdy=%b a=%h b=%h op=%h, required 0 00 5 3 0",
                     rsp_valid, req_ready, alu_a, alu_b, alu_opcode);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || alu_opcode !== 4'hF) begin
            errors++;
            $display("FAIL single_latency: got v=%b op=%h, required 1 f", rsp_valid, alu_opcode);
        end
        drain("single");
    endtask

    task automatic test_zero_flag();
        @(posedge clk); #1;
        drive2(1, 32'd7, 32'd7, 4'd1);
        sb2.push_back('{1, 32'd0, 1'b1});
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (req_ready != 2'b00) break;
        end
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("FAIL zero_ready: got %b, required 10", req_ready);
        end
        @(posedge clk); #1;
        req_valid = '0;
        drain("zero");
    endtask

    task automatic test_round_robin();
        int grants = 0;
        int eid;
        @(posedge clk); #1;
        drive2(0, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd2);
        drive2(1, 32'h1234_5678, 32'h0F0F_0F0F, 4'd2);
        for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            eid = 0;
`else
            eid = k % 2;
`endif
            sb2.push_back('{eid, (eid == 0) ? 32'hF000_F000 : 32'h0204_0608, 1'b0});
        end
        for (int c = 0; c < 60 && grants < 4; c++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                eid = 0;
`else
                eid = grants % 2;
`endif
                checks++;
                if (req_ready !== (2'b01 << eid)) begin
                    errors++;
                    $display("FAIL rr_grant%0d: got %b, required %b", grants, req_ready,
                             2'b01 << eid);
                end
                grants++;
                if (grants == 4) begin
                    @(posedge clk); #1;
                    req_valid = '0;
                end
            end
        end
        checks++;
        if (grants != 4) begin
            errors++;
            $display("FAIL rr_count: got %0d grants, required 4", grants);
        end
        req_valid = '0;
        drain("rr");
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        drive2(0, 32'h8000_0000, 32'd1, 4'd7);
        sb2.push_back('{0, 32'hC000_0000, 1'b0});
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (req_ready != 2'b00) break;
        end
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL bp_ready: got %b, required 01", req_ready);
        end
        @(posedge clk); #1;
        req_valid = '0;
        drive2(1, 32'd100, 32'd58, 4'd0);
        sb2.push_back('{1, 32'd158, 1'b0});
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_valid: got %b, required 1", rsp_valid);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_result !== 32'hC000_0000 || req_ready !== 2'b00) begin
                errors++;
                $display("FAIL bp_hold%0d: got v=%b res=%h rdy=%b, required 1 c0000000 00",
                         c, rsp_valid, rsp_result, req_ready);
            end
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b00) begin
            errors++;
            $display("FAIL bp_accept_cycle: got %b, required 00", req_ready);
        end
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("FAIL bp_next_grant: got %b, required 10", req_ready);
        end
        @(posedge clk); #1;
        req_valid = '0;
        drain("bp");
    endtask

    task automatic test_reset_mid_op();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        drive2(0, 32'd1, 32'd1, 4'd3);
        sb2.push_back('{0, 32'd1, 1'b0});
        @(posedge clk); #1;
        req_valid = '0;
        drain("pre_rst");
        @(posedge clk); #1;
        drive2(1, 32'd3, 32'd4, 4'd0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (req_ready != 2'b00) break;
        end
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("FAIL rst_pre_grant: got %b, required 10", req_ready);
        end
        @(posedge clk); #2;
        req_valid = '0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || alu_opcode !== 4'hF || alu_a !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid: got v=%b op=%h a=%h, required 0 f 0",
                     rsp_valid, alu_opcode, alu_a);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive2(0, 32'd9, 32'd1, 4'd1);
        drive2(1, 32'd2, 32'd2, 4'd0);
        sb2.push_back('{0, 32'd8, 1'b0});
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL rst_first_grant: got %b, required 01", req_ready);
        end
        @(posedge clk); #1;
        req_valid = '0;
        drain("rst");
        repeat (6) @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_stale: got %b, required 0", rsp_valid);
        end
    endtask

    task automatic test_wrap();
        int grants = 0;
        int eid;
        int order[3];
`ifdef ALU_ARB_FIXED_PRIO_EN
        order = '{0, 0, 0};
`else
        order = '{3, 0, 3};
`endif
        w_rsp_ready = 1'b1;
        @(posedge clk); #1;
        drive4(2, 32'd10, 32'd20, 4'd0);
        sb4.push_back('{2, 32'd30, 1'b0});
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (w_req_ready != 4'd0) break;
        end
        checks++;
        if (w_req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL wrap_pre_grant: got %b, required 0100", w_req_ready);
        end
        @(posedge clk); #1;
        w_req_valid = '0;
        drain("wrap_pre");
        @(posedge clk); #1;
        drive4(3, 32'hFFFF_0000, 32'd16, 4'd6);
        drive4(0, 32'd1, 32'd4, 4'd5);
        for (int k = 0; k < 3; k++) begin
            sb4.push_back('{order[k], (order[k] == 3) ? 32'h0000_FFFF : 32'd16, 1'b0});
        end
        for (int c = 0; c < 60 && grants < 3; c++) begin
            @(negedge clk);
            if (w_req_ready != 4'd0) begin
                eid = order[grants];
                checks++;
                if (w_req_ready !== (4'b0001 << eid)) begin
                    errors++;
                    $display("FAIL wrap_grant%0d: got %b, required %b", grants, w_req_ready,
                             4'b0001 << eid);
                end
                grants++;
                if (grants == 3) begin
                    @(posedge clk); #1;
                    w_req_valid = '0;
                end
            end
        end
        checks++;
        if (grants != 3) begin
            errors++;
            $display("FAIL wrap_count: got %0d grants, required 3", grants);
        end
        w_req_valid = '0;
        drain("wrap");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_op();
        test_zero_flag();
        test_round_robin();
        test_backpressure();
        test_reset_mid_op();
        test_wrap();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
